enemy_grid_sequencer: RTL and testbench

Initiator side of the sprite-drawer enable/done handshake. On a frame start it walks a ROWS x COLS grid of enemy slots. For each slot it presents the sprite origin to one enemy sprite drawer, pulses its enable, and waits for the drawer's done before advancing. It sits between the game-tick logic and the shared enemy sprite drawer feeding the VGA adapter.

---
 rtl/enemy_grid_sequencer_pkg.sv | 32 +++
 rtl/enemy_grid_sequencer_if.sv | 31 +++
 rtl/enemy_grid_sequencer_grid_position_counter.sv | 115 +++++++++++
 rtl/enemy_grid_sequencer.sv | 149 ++++++++++++++
 tb/tb_enemy_grid_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_grid_sequencer_pkg.sv
// Shared constants for the enemy grid sequencer: screen widths, sprite size,
// default grid geometry and FSM state encoding.
package enemy_grid_sequencer_pkg;

  localparam int X_W = 9;
  localparam int Y_W = 8;

  localparam int SPRITE_W      = 28;
  localparam int SPRITE_H      = 20;
  localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;

  localparam int DEF_ROWS    = 5;
  localparam int DEF_COLS    = 11;
  localparam int DEF_X_PITCH = 32;
  localparam int DEF_Y_PITCH = 24;

  typedef logic [X_W-1:0] x_pos_t;
  typedef logic [Y_W-1:0] y_pos_t;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] S_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] S_ISSUE     = 3'd1;
  localparam logic [ST_W-1:0] S_WAIT_DONE = 3'd2;
  localparam logic [ST_W-1:0] S_NEXT      = 3'd3;
  localparam logic [ST_W-1:0] S_FINISH    = 3'd4;

  // Index width that stays legal (>= 1 bit) for degenerate 1-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enemy_grid_sequencer_if.sv
// Bundle between the game-tick side, the sequencer and the enemy sprite drawer.
// master = sequencer (drawer initiator), slave = surrounding environment.
interface enemy_grid_sequencer_if
  import enemy_grid_sequencer_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);

  logic                 start;
  x_pos_t               grid_x_origin;
  y_pos_t               grid_y_origin;
  logic [ROWS*COLS-1:0] alive_mask;
  logic                 draw_done;
  logic                 draw_enable;
  x_pos_t               x_pos_init;
  y_pos_t               y_pos_init;
  logic                 busy;
  logic                 frame_done;

  modport master (
    input  start, grid_x_origin, grid_y_origin, alive_mask, draw_done,
    output draw_enable, x_pos_init, y_pos_init, busy, frame_done
  );

  modport slave (
    output start, grid_x_origin, grid_y_origin, alive_mask, draw_done,
    input  draw_enable, x_pos_init, y_pos_init, busy, frame_done
  );

endinterface

// File: rtl/enemy_grid_sequencer_grid_position_counter.sv
// Row/column walker with incremental slot-origin arithmetic (no multiplier).
// ENEMY_SKIP_DEAD_EN adds a linear slot index used for alive-mask lookup.
module grid_position_counter
  import enemy_grid_sequencer_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int X_PITCH = DEF_X_PITCH,
  parameter int Y_PITCH = DEF_Y_PITCH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         load,
  input  logic                         advance,
  input  x_pos_t                       x_origin,
  input  y_pos_t                       y_origin,
  output x_pos_t                       x_pos,
  output y_pos_t                       y_pos,
`ifdef ENEMY_SKIP_DEAD_EN
  output logic [idx_w(ROWS*COLS)-1:0]  slot_idx,
`endif
  output logic                         last_slot
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam x_pos_t X_STEP = X_W'(X_PITCH);
  localparam y_pos_t Y_STEP = Y_W'(Y_PITCH);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  x_pos_t           x_q, x_d, x_org_q, x_org_d;
  y_pos_t           y_q, y_d;

`ifdef ENEMY_SKIP_DEAD_EN
  localparam int SLOT_W = idx_w(ROWS * COLS);
  logic [SLOT_W-1:0] slot_q, slot_d;

  // Linear slot index tracks row*COLS+col by counting advances.
  always_comb begin
    slot_d = slot_q;
    if (load) begin
      slot_d = '0;
    end else if (advance) begin
      slot_d = slot_q + SLOT_W'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot index register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_idx = slot_q;
`endif

  // Column advance adds the pitch; a row wrap reloads x from the latched origin.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    x_d     = x_q;
    y_d     = y_q;
    x_org_d = x_org_q;
    if (load) begin
      row_d   = '0;
      col_d   = '0;
      x_d     = x_origin;
      y_d     = y_origin;
      x_org_d = x_origin;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
        x_d   = x_org_q;
        y_d   = y_q + Y_STEP;
      end else begin
        col_d = col_q + COL_W'(1);
        x_d   = x_q + X_STEP;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Position and grid-coordinate registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_q   <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x_org_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_org_q <= x_org_d;
    end
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign last_slot = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/enemy_grid_sequencer.sv
// Walks the enemy grid once per start, handshaking each slot with the sprite
// drawer. Optional macro ENEMY_SKIP_DEAD_EN skips slots whose alive bit is 0.
module enemy_grid_sequencer
  import enemy_grid_sequencer_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int X_PITCH = DEF_X_PITCH,
  parameter int Y_PITCH = DEF_Y_PITCH
) (
  input  logic                   clk,
  input  logic                   resetn,
  enemy_grid_sequencer_if.master bus
);

  logic [ST_W-1:0] state_q, state_d;
  logic            draw_enable_q, draw_enable_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            load_s, advance_s, last_slot_s;
  x_pos_t          x_pos_s;
  y_pos_t          y_pos_s;

`ifdef ENEMY_SKIP_DEAD_EN
  localparam int SLOTS  = ROWS * COLS;
  localparam int SLOT_W = idx_w(SLOTS);

  logic [SLOTS-1:0]  mask_q, mask_d, mask_shift_s;
  logic [SLOT_W-1:0] slot_idx_s;
  logic              next_alive_s;

  // Alive bit of the slot that an advance would move to.
  always_comb begin
    mask_d       = load_s ? bus.alive_mask : mask_q;
    mask_shift_s = mask_q >> (slot_idx_s + SLOT_W'(1));
    next_alive_s = mask_shift_s[0];
  end

  // Alive mask latched on accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  grid_position_counter #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .X_PITCH (X_PITCH),
    .Y_PITCH (Y_PITCH)
  ) u_pos (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load_s),
    .advance   (advance_s),
    .x_origin  (bus.grid_x_origin),
    .y_origin  (bus.grid_y_origin),
    .x_pos     (x_pos_s),
    .y_pos     (y_pos_s),
`ifdef ENEMY_SKIP_DEAD_EN
    .slot_idx  (slot_idx_s),
`endif
    .last_slot (last_slot_s)
  );

  // Next-state logic; S_NEXT always leaves one idle cycle before the next enable.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_s = 1'b1;
`ifdef ENEMY_SKIP_DEAD_EN
          state_d = bus.alive_mask[0] ? S_ISSUE : S_NEXT;
`else
          state_d = S_ISSUE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.draw_done) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_NEXT: begin
        if (last_slot_s) begin
          state_d = S_FINISH;
        end else begin
          advance_s = 1'b1;
`ifdef ENEMY_SKIP_DEAD_EN
          state_d = next_alive_s ? S_ISSUE : S_NEXT;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    draw_enable_d = (state_d == S_ISSUE);
    frame_done_d  = (state_d == S_FINISH);
    case (state_d)
      S_ISSUE, S_WAIT_DONE, S_NEXT: busy_d = 1'b1;
      default:                      busy_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      draw_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      draw_enable_q <= draw_enable_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.draw_enable = draw_enable_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.x_pos_init  = x_pos_s;
  assign bus.y_pos_init  = y_pos_s;

endmodule

// File: tb/tb_enemy_grid_sequencer.sv
// Scoreboard bench: stimulus pushes expected slot origins computed from grid
// arithmetic; a monitor pops them on every draw_enable. A drawer model answers.
module tb_enemy_grid_sequencer;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int XP   = 32;
  localparam int YP   = 24;
`ifdef ENEMY_SKIP_DEAD_EN
  localparam bit SKIP_DEAD = 1'b1;
`else
  localparam bit SKIP_DEAD = 1'b0;
`endif

  typedef struct { int x; int y; } slot_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  enemy_grid_sequencer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  enemy_grid_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .X_PITCH(XP), .Y_PITCH(YP)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  slot_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, en_count = 0, frames_seen = 0, frames_expected = 0;
  int start_cyc = 0, last_done_cyc = 0, last_en_cyc = -100;
  int pass_en = 0, exp_tail = 0, drawer_delay = 1;
  int pend_x = 0, pend_y = 0;
  bit pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference model: slot (r,c) sits at origin + (c*XP, r*YP), wrapped to screen width.
  function automatic void push_expected(input int ox, input int oy, input logic [ROWS*COLS-1:0] mask);
    int tail;
    tail = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!SKIP_DEAD || mask[r*COLS+c]) begin
          exp_q.push_back('{(ox + c*XP) % 512, (oy + r*YP) % 256});
          tail = 0;
        end else begin
          tail++;
        end
      end
    end
    exp_tail = tail;
    frames_expected++;
  endfunction

  // Drawer model: done pulse arrives a chosen number of cycles after enable.
  initial begin
    int d;
    bus.draw_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resetn && bus.draw_enable) begin
        d = (drawer_delay > 0) ? drawer_delay : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        @(negedge clk); bus.draw_done = 1'b1;
        @(negedge clk); bus.draw_done = 1'b0;
      end
    end
  end

  // Monitor: done seen here was taken by the DUT on the edge just before the sample.
  initial begin
    slot_t e;
    forever begin
      @(posedge clk); #1;
      if (resetn) begin
        if (bus.draw_enable) begin
          chk("enable_gap_ge3", int'((cyc - last_en_cyc) >= 3), 1);
          last_en_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_enable_x", int'(bus.x_pos_init), -1);
          end else begin
            e = exp_q.pop_front();
            chk("enable_x", int'(bus.x_pos_init), e.x);
            chk("enable_y", int'(bus.y_pos_init), e.y);
          end
          pend = 1'b1;
          pend_x = int'(bus.x_pos_init);
          pend_y = int'(bus.y_pos_init);
          pass_en++;
          en_count++;
        end else if (pend) begin
          chk("x_stable_until_done", int'(bus.x_pos_init), pend_x);
          chk("y_stable_until_done", int'(bus.y_pos_init), pend_y);
          if (bus.draw_done) begin
            pend = 1'b0;
            last_done_cyc = cyc;
          end
        end
        if (bus.frame_done) begin
          if (frames_expected == 0) begin
            chk("unexpected_frame_done", 1, 0);
          end else begin
            frames_expected--;
            chk("frame_pending_enables", exp_q.size(), 0);
            chk("busy_low_at_frame_done", int'(bus.busy), 0);
            if (pass_en > 0)
              chk("frame_done_latency", cyc - last_done_cyc, 1 + exp_tail);
            else
              chk("empty_pass_within_8", int'((cyc - start_cyc) <= 8), 1);
          end
          frames_seen++;
          pass_en = 0;
        end
      end
    end
  end

  task automatic pulse_start(input int ox, input int oy, input logic [ROWS*COLS-1:0] mask, input bit accepted);
    @(negedge clk);
    bus.start = 1'b1;
    bus.grid_x_origin = 9'(ox);
    bus.grid_y_origin = 8'(oy);
    bus.alive_mask = mask;
    @(posedge clk); #1;
    if (accepted) begin
      start_cyc = cyc;
      chk("busy_after_start", int'(bus.busy), 1);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_enables(input int target);
    int t;
    t = 0;
    while (en_count < target && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    if (en_count < target) chk("enable_timeout", en_count, target);
  endtask

  task automatic wait_frame(input int target);
    int t;
    t = 0;
    while (frames_seen < target && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (frames_seen < target) chk("pass_timeout", frames_seen, target);
    repeat (6) @(posedge clk);
  endtask

  task automatic run_pass(input int ox, input int oy, input logic [ROWS*COLS-1:0] mask,
                          input int delay, input bit poke);
    int f0, base;
    drawer_delay = delay;
    f0 = frames_seen;
    base = en_count;
    push_expected(ox, oy, mask);
    pulse_start(ox, oy, mask, 1'b1);
    if (poke) begin
      wait_enables(base + 2);
      pulse_start((ox + 77) % 512, (oy + 33) % 256, mask, 1'b0);
    end
    wait_frame(f0 + 1);
    if (poke) repeat (30) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_draw_enable"}, int'(bus.draw_enable), 0);
    chk({tag, "_busy"},        int'(bus.busy), 0);
    chk({tag, "_frame_done"},  int'(bus.frame_done), 0);
    chk({tag, "_x"},           int'(bus.x_pos_init), 0);
    chk({tag, "_y"},           int'(bus.y_pos_init), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.grid_x_origin = '0;
    bus.grid_y_origin = '0;
    bus.alive_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    run_pass(10, 5, 6'h3F, 562, 1'b0);
    run_pass(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 6'h3F, 1, 1'b0);
    run_pass(500, 250, 6'h3F, 2, 1'b0);
    run_pass(200, 100, 6'h3F, 0, 1'b1);

    // Reset while the sequencer waits on the drawer.
    begin
      int base;
      base = en_count;
      drawer_delay = 30;
      push_expected(100, 40, 6'h3F);
      pulse_start(100, 40, 6'h3F, 1'b1);
      wait_enables(base + 2);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_outputs_zero("midpass_reset");
      exp_q.delete();
      frames_expected = 0;
      pend = 1'b0;
      pass_en = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(posedge clk);
    end
    run_pass(0, 0, 6'h3F, 0, 1'b0);

`ifdef ENEMY_SKIP_DEAD_EN
    run_pass(10, 5, 6'b101010, 2, 1'b0);
    run_pass(10, 5, 6'b000000, 1, 1'b0);
    run_pass(30, 60, 6'b000011, 1, 1'b0);
`endif

    for (int i = 0; i < 8; i++) begin
      run_pass(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
               6'($urandom_range(0, 63)), 0, 1'b0);
    end

    chk("no_leftover_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_expired actual=%0d required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
